// File: rtl/viterbi_sel_mux_pipe.sv
// Registered NUM_IN:1 word selector with a 2-entry skid buffer and out-of-range select reporting.
// Optional macro VITERBI_SEL_HOLD_LAST_EN: out-of-range selects replay the last in-range word instead of zero.
module viterbi_sel_mux_pipe #(
  parameter int NUM_IN   = 4,
  parameter int DATA_W   = 2,
  parameter int SEL_W    = 2,
  parameter int ERRCNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_oob,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sel_err,
  input  logic                     err_clr,
  output logic [ERRCNT_W-1:0]      err_cnt
);

  localparam logic [ERRCNT_W-1:0] CNT_ONE = ERRCNT_W'(1);
  localparam logic [ERRCNT_W-1:0] CNT_MAX = {ERRCNT_W{1'b1}};

  if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
    $error("viterbi_sel_mux_pipe: NUM_IN must be in 2..16");
  end
  if (DATA_W < 1 || DATA_W > 32) begin : g_bad_data_w
    $error("viterbi_sel_mux_pipe: DATA_W must be in 1..32");
  end
  if ((1 << SEL_W) < NUM_IN) begin : g_bad_sel_w
    $error("viterbi_sel_mux_pipe: SEL_W too narrow for NUM_IN");
  end

  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // head_* is the beat on the output, skid_* the second buffered beat
  logic                head_valid_r, head_valid_s;
  logic [DATA_W-1:0]   head_data_r, head_data_s;
  logic [SEL_W-1:0]    head_sel_r, head_sel_s;
  logic                head_oob_r, head_oob_s;
  logic                skid_valid_r, skid_valid_s;
  logic [DATA_W-1:0]   skid_data_r, skid_data_s;
  logic [SEL_W-1:0]    skid_sel_r, skid_sel_s;
  logic                skid_oob_r, skid_oob_s;
  logic                in_ready_r, in_ready_s;
  logic                sel_err_r, sel_err_s;
  logic [ERRCNT_W-1:0] err_cnt_r, err_cnt_s;
  logic [DATA_W-1:0]   word_s, new_data_s;
  logic                new_oob_s, push_s, pop_s;
`ifdef VITERBI_SEL_HOLD_LAST_EN
  logic [DATA_W-1:0]   hold_r, hold_s;
`endif

  // Word selection from the flattened input bus plus range check
  always_comb begin
    word_s    = {DATA_W{1'b0}};
    new_oob_s = (int'(in_sel) >= NUM_IN);
    for (int i = 0; i < NUM_IN; i++) begin
      word_s = word_s | ({DATA_W{(int'(in_sel) == i)}} & in_data[i*DATA_W +: DATA_W]);
    end
`ifdef VITERBI_SEL_HOLD_LAST_EN
    new_data_s = new_oob_s ? hold_r : word_s;
`else
    new_data_s = new_oob_s ? {DATA_W{1'b0}} : word_s;
`endif
  end

  assign push_s = in_valid & in_ready_r;
  assign pop_s  = head_valid_r & out_ready;

  // Next-state for the two-entry buffer, ready flag and error tracking
  always_comb begin
    head_valid_s = head_valid_r;
    head_data_s  = head_data_r;
    head_sel_s   = head_sel_r;
    head_oob_s   = head_oob_r;
    skid_valid_s = skid_valid_r;
    skid_data_s  = skid_data_r;
    skid_sel_s   = skid_sel_r;
    skid_oob_s   = skid_oob_r;
    sel_err_s    = sel_err_r;
    err_cnt_s    = err_cnt_r;
`ifdef VITERBI_SEL_HOLD_LAST_EN
    hold_s       = hold_r;
`endif
    if (!head_valid_r) begin
      if (push_s) begin
        head_valid_s = 1'b1;
        head_data_s  = new_data_s;
        head_sel_s   = in_sel;
        head_oob_s   = new_oob_s;
      end else begin
        head_valid_s = 1'b0;
      end
    end else if (pop_s) begin
      // in_ready is low whenever the skid entry is full, so no push competes here
      if (skid_valid_r) begin
        head_data_s  = skid_data_r;
        head_sel_s   = skid_sel_r;
        head_oob_s   = skid_oob_r;
        skid_valid_s = 1'b0;
      end else if (push_s) begin
        head_data_s  = new_data_s;
        head_sel_s   = in_sel;
        head_oob_s   = new_oob_s;
      end else begin
        head_valid_s = 1'b0;
      end
    end else begin
      if (push_s) begin
        skid_valid_s = 1'b1;
        skid_data_s  = new_data_s;
        skid_sel_s   = in_sel;
        skid_oob_s   = new_oob_s;
      end else begin
        skid_valid_s = skid_valid_r;
      end
    end
    in_ready_s = ~skid_valid_s;

    // An out-of-range accept takes priority over a coincident clear
    if (push_s && new_oob_s) begin
      sel_err_s = 1'b1;
      err_cnt_s = err_clr ? CNT_ONE : sat_inc(err_cnt_r);
    end else if (err_clr) begin
      sel_err_s = 1'b0;
      err_cnt_s = {ERRCNT_W{1'b0}};
    end else begin
      sel_err_s = sel_err_r;
    end
`ifdef VITERBI_SEL_HOLD_LAST_EN
    if (push_s && !new_oob_s) begin
      hold_s = word_s;
    end else begin
      hold_s = hold_r;
    end
`endif
  end

  // State registers; async reset discards buffered beats immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_valid_r <= 1'b0;
      head_data_r  <= {DATA_W{1'b0}};
      head_sel_r   <= {SEL_W{1'b0}};
      head_oob_r   <= 1'b0;
      skid_valid_r <= 1'b0;
      skid_data_r  <= {DATA_W{1'b0}};
      skid_sel_r   <= {SEL_W{1'b0}};
      skid_oob_r   <= 1'b0;
      in_ready_r   <= 1'b0;
      sel_err_r    <= 1'b0;
      err_cnt_r    <= {ERRCNT_W{1'b0}};
`ifdef VITERBI_SEL_HOLD_LAST_EN
      hold_r       <= {DATA_W{1'b0}};
`endif
    end else begin
      head_valid_r <= head_valid_s;
      head_data_r  <= head_data_s;
      head_sel_r   <= head_sel_s;
      head_oob_r   <= head_oob_s;
      skid_valid_r <= skid_valid_s;
      skid_data_r  <= skid_data_s;
      skid_sel_r   <= skid_sel_s;
      skid_oob_r   <= skid_oob_s;
      in_ready_r   <= in_ready_s;
      sel_err_r    <= sel_err_s;
      err_cnt_r    <= err_cnt_s;
`ifdef VITERBI_SEL_HOLD_LAST_EN
      hold_r       <= hold_s;
`endif
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = head_valid_r;
  assign out_data  = head_data_r;
  assign out_sel   = head_sel_r;
  assign out_oob   = head_oob_r;
  assign sel_err   = sel_err_r;
  assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_viterbi_sel_mux_pipe.sv
// Scoreboard bench for viterbi_sel_mux_pipe (NUM_IN=3 so select 3 is out of range).
module tb_viterbi_sel_mux_pipe;
  localparam int NUM_IN   = 3;
  localparam int DATA_W   = 4;
  localparam int SEL_W    = 2;
  localparam int ERRCNT_W = 8;
  localparam int CNT_MAX  = (1 << ERRCNT_W) - 1;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_IN*DATA_W-1:0] in_data = '0;
  logic [SEL_W-1:0]         in_sel = '0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_sel;
  logic                     out_oob;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic                     sel_err;
  logic                     err_clr = 1'b0;
  logic [ERRCNT_W-1:0]      err_cnt;

  viterbi_sel_mux_pipe #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .SEL_W(SEL_W), .ERRCNT_W(ERRCNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel), .out_oob(out_oob),
    .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err), .err_clr(err_clr),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned data;
    int unsigned sel;
    bit          oob;
  } beat_t;

  beat_t       exp_q[$];
  int          tests = 0;
  int          fails = 0;
  bit          armed = 1'b0;
  bit          rdy_rand = 1'b0;
  bit          m_err = 1'b0;
  int unsigned m_cnt = 0;
  int unsigned m_hold = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of expected beats plus error bookkeeping, evaluated mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      armed  = 1'b0;
      m_err  = 1'b0;
      m_cnt  = 0;
      m_hold = 0;
    end else begin
      chk("out_valid", out_valid, exp_q.size() != 0);
      chk("in_ready", in_ready, armed && exp_q.size() != 2);
      chk("sel_err", sel_err, m_err);
      chk("err_cnt", err_cnt, m_cnt);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          chk("out_data", out_data, b.data);
          chk("out_sel", out_sel, b.sel);
          chk("out_oob", out_oob, b.oob);
        end
      end
      if (in_valid && in_ready) begin
        beat_t b;
        int unsigned s, w;
        s = in_sel;
        b.sel = s;
        b.oob = (s >= NUM_IN);
        if (!b.oob) begin
          w = (int'(in_data) >> (s * DATA_W)) & ((1 << DATA_W) - 1);
          b.data = w;
          m_hold = w;
        end else begin
`ifdef VITERBI_SEL_HOLD_LAST_EN
          b.data = m_hold;
`else
          b.data = 0;
`endif
          m_err = 1'b1;
          if (err_clr) m_cnt = 1;
          else if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end
        exp_q.push_back(b);
      end else if (err_clr) begin
        m_err = 1'b0;
        m_cnt = 0;
      end
      if (!b_is_oob_accept() && err_clr && in_valid && in_ready) begin
        m_err = 1'b0;
        m_cnt = 0;
      end
      armed = 1'b1;
    end
  end

  // An in-range accept coinciding with err_clr still clears the error state
  function automatic bit b_is_oob_accept();
    return int'(in_sel) >= NUM_IN;
  endfunction

  // Random back-pressure generator for the mixed-traffic phase
  always @(posedge clk) begin
    if (rdy_rand) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [SEL_W-1:0] s, input logic [NUM_IN*DATA_W-1:0] d, input logic clr);
    int n;
    bit got;
    n = 0;
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
    err_clr  = clr;
    do begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!got && n < 200);
    if (!got) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
    err_clr  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", out_valid, 0);
  endtask

  logic [NUM_IN*DATA_W-1:0] pat;
  logic [DATA_W-1:0]        a_word;

  initial begin
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_out_oob", out_oob, 0);
    chk("rst_sel_err", sel_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(2);

    // in-range selects on consecutive cycles
    pat = 12'hA5C;
    for (int i = 0; i < NUM_IN; i++) send(SEL_W'(i), pat, 1'b0);
    // single out-of-range select
    send(2'd3, pat, 1'b0);
    chk("oob_flag", out_oob, 1);
    chk("oob_sel_err", sel_err, 1);
    chk("oob_err_cnt", err_cnt, 1);
`ifdef VITERBI_SEL_HOLD_LAST_EN
    chk("oob_hold_data", out_data, 4'hA);
`else
    chk("oob_zero_data", out_data, 0);
`endif
    drain();

    // back-pressure: A and B fill the buffer, C waits
    out_ready = 1'b0;
    a_word = 4'h6;
    fork
      begin
        repeat (4) @(posedge clk);
        #2;
        chk("bp_hold_a", out_data, a_word);
        chk("bp_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
      end
    join_none
    send(2'd0, 12'h126, 1'b0);
    send(2'd1, 12'h3B0, 1'b0);
    send(2'd2, 12'hD00, 1'b0);
    idle(1);
    drain();

    // randomized traffic with random back-pressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send(SEL_W'($urandom_range(0, 3)), (NUM_IN*DATA_W)'($urandom), 1'($urandom_range(0, 15) == 0));
    end
    rdy_rand = 1'b0;
    idle(1);
    drain();

    // saturation of the error counter
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) send(2'd3, (NUM_IN*DATA_W)'($urandom), 1'b0);
    chk("sat_err_cnt", err_cnt, CNT_MAX);
    chk("sat_sel_err", sel_err, 1);
    send(2'd3, pat, 1'b1);
    chk("clr_vs_oob_cnt", err_cnt, 1);
    chk("clr_vs_oob_err", sel_err, 1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    chk("clr_cnt", err_cnt, 0);
    chk("clr_err", sel_err, 0);
    drain();

    // reset with two beats buffered
    out_ready = 1'b0;
    send(2'd1, 12'h5F0, 1'b0);
    send(2'd2, 12'h700, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_data", out_data, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(6);
    chk("post_rst_no_beat", out_valid, 0);
    chk("post_rst_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
